// File: rtl/fc_mover_mac_array.sv
// Fully-connected data mover: streams node/weight words from BRAM into NUM_CORE
// signed MAC lanes, then biases, ReLUs, saturates and writes one result per lane.
module fc_mover_mac_array #(
   parameter int NUM_CORE      = 4,
   parameter int IN_DATA_WIDTH = 16,
   parameter int ACC_WIDTH     = 48,
   parameter int DWIDTH        = 32,
   parameter int AWIDTH        = 12,
   parameter int CNT_BIT       = 31
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              i_run,
   input  logic [CNT_BIT-1:0]                i_num_cnt,
   input  logic                              i_relu_en,
   input  logic [AWIDTH-1:0]                 i_wr_base,
   input  logic [NUM_CORE*IN_DATA_WIDTH-1:0] i_bias,
   output logic                              o_idle,
   output logic                              o_read,
   output logic                              o_write,
   output logic                              o_done,
   output logic [AWIDTH-1:0]                 addr_n,
   output logic                              ce_n,
   input  logic [DWIDTH-1:0]                 q_n,
   output logic [AWIDTH-1:0]                 addr_w,
   output logic                              ce_w,
   input  logic [NUM_CORE*DWIDTH-1:0]        q_w,
   output logic [AWIDTH-1:0]                 addr_r,
   output logic                              ce_r,
   output logic                              we_r,
   output logic [DWIDTH-1:0]                 d_r,
   output logic [NUM_CORE*DWIDTH-1:0]        o_result
);

   localparam int IW   = IN_DATA_WIDTH;
   localparam int WC_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

   // Clip limits expressed at the widened (ACC_WIDTH+1) sum width so the compare stays signed.
   localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};
   localparam logic [DWIDTH-1:0] D_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] D_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_FINAL, S_WRITE, S_DONE} state_t;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [CNT_BIT-1:0]          r_num_cnt;
   logic                        r_relu_en;
   logic [AWIDTH-1:0]           r_wr_base;
   logic [NUM_CORE*IW-1:0]      r_bias;
   logic [CNT_BIT-1:0]          r_rd_cnt;
   logic [WC_W-1:0]             r_wr_cnt;
   logic                        r_valid;
   logic [ACC_WIDTH-1:0]        r_acc    [NUM_CORE];
   logic [DWIDTH-1:0]           r_result [NUM_CORE];
   logic [ACC_WIDTH-1:0]        w_prod_ext [NUM_CORE];
   logic [DWIDTH-1:0]           w_sat      [NUM_CORE];
   logic                        w_start;
   logic                        w_last_rd;
   logic                        w_last_wr;

   assign w_start   = (r_state == S_IDLE) && i_run;
   assign w_last_rd = (r_rd_cnt == (r_num_cnt - CNT_BIT'(1)));
   assign w_last_wr = (r_wr_cnt == WC_W'(NUM_CORE - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_run) w_state_next = (i_num_cnt == '0) ? S_FINAL : S_READ;
         S_READ:  if (w_last_rd) w_state_next = S_DRAIN;
         S_DRAIN: w_state_next = S_FINAL;
         S_FINAL: w_state_next = S_WRITE;
         S_WRITE: if (w_last_wr) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_idle  = 1'b0;
      o_read  = 1'b0;
      o_write = 1'b0;
      o_done  = 1'b0;
      ce_n    = 1'b0;
      ce_w    = 1'b0;
      ce_r    = 1'b0;
      we_r    = 1'b0;
      addr_n  = '0;
      addr_w  = '0;
      addr_r  = '0;
      d_r     = '0;
      case (r_state)
         S_IDLE: o_idle = 1'b1;
         S_READ: begin
            o_read = 1'b1;
            ce_n   = 1'b1;
            ce_w   = 1'b1;
            addr_n = r_rd_cnt[AWIDTH-1:0];
            addr_w = r_rd_cnt[AWIDTH-1:0];
         end
         S_WRITE: begin
            o_write = 1'b1;
            ce_r    = 1'b1;
            we_r    = 1'b1;
            addr_r  = r_wr_base + AWIDTH'(r_wr_cnt);
            d_r     = r_result[r_wr_cnt];
         end
         S_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   // Per-lane product and post-processing; only the low IW bits of each BRAM word matter.
   for (genvar gi = 0; gi < NUM_CORE; gi++) begin : g_lane
      logic [2*IW-1:0]             w_a;
      logic [2*IW-1:0]             w_b;
      logic [2*IW-1:0]             w_prod;
      logic [IW-1:0]               w_bias;
      logic signed [ACC_WIDTH:0]   w_sum;
      logic signed [ACC_WIDTH:0]   w_relu;

      assign w_a    = {{IW{q_n[IW-1]}}, q_n[IW-1:0]};
      assign w_b    = {{IW{q_w[gi*DWIDTH+IW-1]}}, q_w[gi*DWIDTH +: IW]};
      assign w_prod = w_a * w_b;
      assign w_prod_ext[gi] = {{(ACC_WIDTH-2*IW){w_prod[2*IW-1]}}, w_prod};

      assign w_bias = r_bias[gi*IW +: IW];
      assign w_sum  = {r_acc[gi][ACC_WIDTH-1], r_acc[gi]} +
                      {{(ACC_WIDTH+1-IW){w_bias[IW-1]}}, w_bias};
      assign w_relu = (r_relu_en && w_sum[ACC_WIDTH]) ? '0 : w_sum;
      assign w_sat[gi] = (w_relu > SAT_MAX) ? D_MAX :
                         (w_relu < SAT_MIN) ? D_MIN : w_relu[DWIDTH-1:0];

      assign o_result[gi*DWIDTH +: DWIDTH] = r_result[gi];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_num_cnt <= '0;
         r_relu_en <= 1'b0;
         r_wr_base <= '0;
         r_bias    <= '0;
         r_rd_cnt  <= '0;
         r_wr_cnt  <= '0;
         r_valid   <= 1'b0;
         for (int k = 0; k < NUM_CORE; k++) begin
            r_acc[k]    <= '0;
            r_result[k] <= '0;
         end
      end else begin
         r_valid <= (r_state == S_READ);
         if (w_start) begin
            r_num_cnt <= i_num_cnt;
            r_relu_en <= i_relu_en;
            r_wr_base <= i_wr_base;
            r_bias    <= i_bias;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
         end
         if (r_state == S_READ)  r_rd_cnt <= r_rd_cnt + CNT_BIT'(1);
         if (r_state == S_WRITE) r_wr_cnt <= r_wr_cnt + WC_W'(1);
         for (int k = 0; k < NUM_CORE; k++) begin
            if (w_start) begin
               r_acc[k] <= '0;
            end else if (r_valid) begin
               r_acc[k] <= r_acc[k] + w_prod_ext[k];
            end
            if (r_state == S_FINAL) r_result[k] <= w_sat[k];
         end
      end
   end

endmodule
